// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared FSM state type and CSR constants for the ADC sample reader
package adc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_IER,
        ST_RUN,
        ST_WAIT_IRQ,
        ST_RD,
        ST_RD_WAIT,
        ST_PUSH,
        ST_ACK,
        ST_HALT
    } adc_state_t;

    localparam logic [6:0] SS_IER_ADDR  = 7'd64;
    localparam logic [6:0] SS_ISR_ADDR  = 7'd65;
    localparam logic       SEQ_CMD_ADDR = 1'b0;
    localparam logic [2:0] MODE_CONT    = 3'b000;
    localparam logic [2:0] MODE_SINGLE  = 3'b001;

endpackage

// File: rtl/adc_sample_reader.sv
// rtl/adc_sample_reader.sv - Avalon-MM master that runs the ADC sequencer and streams sample-store slots
//
// Ports:
//   clock_clk, reset_sink_reset_n : clock, asynchronous active-low reset
//   start, stop                   : one-cycle control pulses
//   seq_*                         : sequencer CSR master (write only)
//   ss_*                          : sample-store CSR master, ss_irq end-of-sequence interrupt
//   smp_*                         : sample stream (valid/ready), slot index and last-slot flag
//   busy, frame_count             : status
module adc_sample_reader
    import adc_pkg::*;
#(
    parameter int NUM_SLOTS     = 8,
    parameter int SS_RD_LATENCY = 2,
    parameter int CONTINUOUS    = 1
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset_n,
    input  logic        start,
    input  logic        stop,
    output logic        seq_address,
    output logic        seq_write,
    output logic [31:0] seq_writedata,
    output logic [6:0]  ss_address,
    output logic        ss_read,
    output logic        ss_write,
    output logic [31:0] ss_writedata,
    input  logic [31:0] ss_readdata,
    input  logic        ss_irq,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [11:0] smp_data,
    output logic [5:0]  smp_slot,
    output logic        smp_last,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam logic [5:0] SLOT_LAST = 6'(NUM_SLOTS - 1);
    localparam logic [2:0] LAT_LAST  = 3'(SS_RD_LATENCY - 1);
    localparam logic [2:0] MODE      = (CONTINUOUS != 0) ? MODE_CONT : MODE_SINGLE;

    adc_state_t  state_q, state_d;
    logic [5:0]  slot_q, slot_d;
    logic [2:0]  lat_q, lat_d;
    logic [11:0] data_q, data_d;
    logic [15:0] frame_q, frame_d;
    logic        stop_q, stop_d;

    logic        seq_write_q, seq_write_d;
    logic [31:0] seq_wdata_q, seq_wdata_d;
    logic [6:0]  ss_addr_q, ss_addr_d;
    logic        ss_read_q, ss_read_d;
    logic        ss_write_q, ss_write_d;
    logic [31:0] ss_wdata_q, ss_wdata_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;

    // Only the 12-bit conversion result is used.
    logic unused_rd_bits;
    assign unused_rd_bits = ^ss_readdata[31:12];

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        lat_d   = lat_q;
        data_d  = data_q;
        frame_d = frame_q;
        stop_d  = stop_q | stop;

        case (state_q)
            ST_IDLE:     if (start) state_d = ST_IER;
            ST_IER:      state_d = ST_RUN;
            ST_RUN:      state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                if (ss_irq) begin
                    slot_d  = 6'd0;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                lat_d   = 3'd0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = ss_readdata[11:0];
                    state_d = ST_PUSH;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_PUSH: begin
                // smp_valid is registered high for the whole PUSH state.
                if (smp_ready) begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_ACK;
                    end else begin
                        slot_d  = slot_q + 6'd1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_ACK: begin
                frame_d = frame_q + 16'd1;
                // A stop arriving in the ACK cycle still ends after this frame.
                if (stop_q || stop)        state_d = ST_HALT;
                else if (CONTINUOUS != 0)  state_d = ST_WAIT_IRQ;
                else                       state_d = ST_RUN;
            end
            ST_HALT:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE && state_q != ST_IDLE) stop_d = 1'b0;

        // Bus and stream outputs are decoded from the next state so they are
        // registered and line up with the cycle spent in that state.
        seq_write_d = (state_d == ST_RUN) || (state_d == ST_HALT);
        seq_wdata_d = (state_d == ST_RUN) ? {28'd0, MODE, 1'b1} : 32'd0;
        ss_write_d  = (state_d == ST_IER) || (state_d == ST_ACK);
        ss_wdata_d  = ss_write_d ? 32'd1 : 32'd0;
        ss_read_d   = (state_d == ST_RD);
        case (state_d)
            ST_IER:  ss_addr_d = SS_IER_ADDR;
            ST_ACK:  ss_addr_d = SS_ISR_ADDR;
            ST_RD:   ss_addr_d = {1'b0, slot_d};
            default: ss_addr_d = 7'd0;
        endcase
        valid_d = (state_d == ST_PUSH);
        last_d  = (state_d == ST_PUSH) && (slot_d == SLOT_LAST);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= 6'd0;
            lat_q       <= 3'd0;
            data_q      <= 12'd0;
            frame_q     <= 16'd0;
            stop_q      <= 1'b0;
            seq_write_q <= 1'b0;
            seq_wdata_q <= 32'd0;
            ss_addr_q   <= 7'd0;
            ss_read_q   <= 1'b0;
            ss_write_q  <= 1'b0;
            ss_wdata_q  <= 32'd0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            lat_q       <= lat_d;
            data_q      <= data_d;
            frame_q     <= frame_d;
            stop_q      <= stop_d;
            seq_write_q <= seq_write_d;
            seq_wdata_q <= seq_wdata_d;
            ss_addr_q   <= ss_addr_d;
            ss_read_q   <= ss_read_d;
            ss_write_q  <= ss_write_d;
            ss_wdata_q  <= ss_wdata_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    assign seq_address   = SEQ_CMD_ADDR;
    assign seq_write     = seq_write_q;
    assign seq_writedata = seq_wdata_q;
    assign ss_address    = ss_addr_q;
    assign ss_read       = ss_read_q;
    assign ss_write      = ss_write_q;
    assign ss_writedata  = ss_wdata_q;
    assign smp_valid     = valid_q;
    assign smp_data      = data_q;
    assign smp_slot      = slot_q;
    assign smp_last      = last_q;
    assign busy          = busy_q;
    assign frame_count   = frame_q;

endmodule
